// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Define MULDIV_DIV_EN to compile in the divide datapath; otherwise DIV/DIVU complete as reserved ops.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    // FIN is the single write-back cycle shared by iterative and register-move ops.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_op;
    logic [WIDTH-1:0]    r_acc;
    logic [WIDTH-1:0]    r_q;
    logic [WIDTH-1:0]    r_b;
    logic                r_neg_lo;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic                r_busy;
    logic                r_done;
    logic                r_dz;
    logic                r_err;

    logic                w_accept;
    logic                w_is_md;
    logic                w_sgn;
    logic [WIDTH:0]      w_madd;
    logic [WIDTH-1:0]    w_acc_nxt;
    logic [WIDTH-1:0]    w_q_nxt;
    logic [2*WIDTH-1:0]  w_prod_fix;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        logic signed [WIDTH-1:0] s;
        s = x;
        return (sgn && (s < 0)) ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_if2(input logic [2*WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    assign w_accept = (r_state == S_IDLE) && start && !abort;
    assign w_sgn    = (op == 3'b000) || (op == 3'b010);

    always_comb begin
        w_is_md = (op == 3'b000) || (op == 3'b001);
`ifdef MULDIV_DIV_EN
        if ((op == 3'b010) || (op == 3'b011)) begin
            w_is_md = 1'b1;
        end
`endif
    end

`ifdef MULDIV_DIV_EN
    logic                r_neg_hi;
    logic [WIDTH:0]      w_trial;
    logic [WIDTH-1:0]    w_quo_fix;
    logic [WIDTH-1:0]    w_rem_fix;

    assign w_trial   = {r_acc, r_q[WIDTH-1]} - {1'b0, r_b};
    assign w_quo_fix = neg_if(r_q, r_neg_lo);
    assign w_rem_fix = neg_if(r_acc, r_neg_hi);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_neg_hi <= w_sgn && in0[WIDTH-1];
        end
    end
`endif

    // Multiply: acc:q shifts right, adding the multiplicand when the low multiplier bit is set.
    assign w_madd     = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    assign w_prod_fix = neg_if2({r_acc, r_q}, r_neg_lo);

    always_comb begin
        w_acc_nxt = w_madd[WIDTH:1];
        w_q_nxt   = {w_madd[0], r_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        // Restoring divide: remainder in acc, dividend shifts out of q as quotient bits shift in.
        if (r_op[1]) begin
            if (!w_trial[WIDTH]) begin
                w_acc_nxt = w_trial[WIDTH-1:0];
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // p0: operand capture (magnitudes for signed ops) and per-cycle iteration
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op     <= op;
            r_acc    <= '0;
            r_q      <= magnitude(in0, w_sgn);
            r_b      <= magnitude(in1, w_sgn);
            r_neg_lo <= w_sgn && (in0[WIDTH-1] ^ in1[WIDTH-1]);
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
        end
    end

    // p1: control FSM and architectural HI/LO write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        if (w_is_md) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_FIN;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FIN;
                        r_busy  <= 1'b0;
                    end
                end
                S_FIN: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    case (r_op)
                        3'b000, 3'b001: {r_hi, r_lo} <= w_prod_fix;
`ifdef MULDIV_DIV_EN
                        3'b010, 3'b011: begin
                            if (r_b == '0) begin
                                r_dz <= 1'b1;
                            end else begin
                                r_hi <= w_rem_fix;
                                r_lo <= w_quo_fix;
                            end
                        end
`endif
                        3'b100:  r_hi  <= r_q;
                        3'b101:  r_lo  <= r_q;
                        default: r_err <= 1'b1;
                    endcase
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dz   = r_dz;
    assign err  = r_err;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: arithmetic reference model, randomized and directed operations.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] in0 = '0;
    logic [W-1:0] in1 = '0;
    logic         busy, done, dz, err;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        logic         err;
        int           lat;
        int           nbusy;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           n_tests = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           done_cnt = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op),
        .in0(in0), .in1(in1), .busy(busy), .done(done), .dz(dz), .err(err),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: plain 64-bit / integer arithmetic on the architectural HI/LO state.
    task automatic predict(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output exp_t e);
        longint     sp;
        logic [63:0] up;
        int         sq, sr;
        e.dz = 1'b0; e.err = 1'b0; e.lat = 1; e.nbusy = 0; e.acc = 0;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {m_hi, m_lo} = sp;
                e.lat = W + 1; e.nbusy = W;
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = up;
                e.lat = W + 1; e.nbusy = W;
            end
`ifdef MULDIV_DIV_EN
            3'd2: begin
                e.lat = W + 1; e.nbusy = W;
                if (b == 0) e.dz = 1'b1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a; m_hi = '0;
                end else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    m_lo = sq; m_hi = sr;
                end
            end
            3'd3: begin
                e.lat = W + 1; e.nbusy = W;
                if (b == 0) e.dz = 1'b1;
                else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
`endif
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: e.err = 1'b1;
        endcase
        e.hi = m_hi; e.lo = m_lo;
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports completion.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no completion (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("hi", 64'(hi), 64'(mon_e.hi));
                chk("lo", 64'(lo), 64'(mon_e.lo));
                chk("dz", 64'(dz), 64'(mon_e.dz));
                chk("err", 64'(err), 64'(mon_e.err));
                chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
            end
        end else begin
            chk("dz_err_unqualified", {62'd0, dz, err}, 64'd0);
        end
    end

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            output int acc);
        op = o; in0 = a; in1 = b; start = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        start = 1'b0; in0 = $urandom; in1 = $urandom; op = 3'($urandom);
        @(negedge clk);
    endtask

    task automatic wait_done(input string name, input int exp_busy, input bit chk_busy);
        int nb;
        bit seen;
        nb = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nb++;
            @(negedge clk);
        end
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
        if (chk_busy) chk({name, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
        @(negedge clk);
    endtask

    task automatic send(input string name, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        exp_t e;
        int   acc;
        predict(o, a, b, e);
        start_op(o, a, b, acc);
        e.acc = acc;
        sb.push_back(e);
        wait_done(name, e.nbusy, 1'b1);
    endtask

    initial begin
        exp_t e;
        int   acc, d0;
        #1;
        chk("reset_ctrl", {60'd0, busy, done, dz, err}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send("mult_neg", 3'd0, 32'hFFFF_FFFF, 32'd2);
        send("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send("mthi", 3'd4, 32'h1234, 32'd0);
`ifdef MULDIV_DIV_EN
        send("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
        send("divu", 3'd3, 32'd7, 32'd2);
        send("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
`endif
        send("mthi_a", 3'd4, 32'hA, 32'd0);
        send("mtlo_b", 3'd5, 32'hB, 32'd0);
        send("divu_zero", 3'd3, 32'd5, 32'd0);

        // Second start during RUN must be dropped.
        d0 = done_cnt;
        predict(3'd0, 32'd12345, 32'hFFFF_FF00, e);
        start_op(3'd0, 32'd12345, 32'hFFFF_FF00, acc);
        e.acc = acc;
        sb.push_back(e);
        repeat (4) @(negedge clk);
        op = 3'd4; in0 = 32'hDEAD_BEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("mult_ignore", 0, 1'b0);
        repeat (5) @(negedge clk);
        #1 chk("single_done", 64'(done_cnt - d0), 64'd1);

        // Abort mid-operation.
        d0 = done_cnt;
`ifdef MULDIV_DIV_EN
        start_op(3'd2, 32'd100, 32'd7, acc);
`else
        start_op(3'd0, 32'd100, 32'd7, acc);
`endif
        repeat (9) @(negedge clk);
        chk("abort_busy_before", 64'(busy), 64'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy_drop", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        #1 chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_hilo", {hi, lo}, {m_hi, m_lo});
        @(negedge clk);

        // abort wins over start in IDLE.
        d0 = done_cnt;
        op = 3'd0; in0 = 32'd3; in1 = 32'd5; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        #1 chk("abort_start_no_done", 64'(done_cnt - d0), 64'd0);
        @(negedge clk);

        send("reserved_110", 3'd6, 32'h77, 32'h88);
        send("reserved_111", 3'd7, 32'h99, 32'h11);

        for (int i = 0; i < 60; i++) begin
            send("rand", 3'($urandom_range(0, 7)), rnd_val(), rnd_val());
        end

        // Asynchronous reset in the middle of RUN.
        send("mthi_pre", 3'd4, 32'h55AA, 32'd0);
        d0 = done_cnt;
        start_op(3'd0, 32'd123, 32'd456, acc);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_ctrl", {62'd0, busy, done}, 64'd0);
        chk("rst_async_hilo", {hi, lo}, 64'd0);
        #1 rst = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        repeat (40) @(negedge clk);
        #1 chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
        @(negedge clk);
        send("mult_after_rst", 3'd0, 32'd7, 32'hFFFF_FFFD);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
